// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit with a registered valid/ready output
// stage and a one-entry skid register so in_ready comes straight from a flop.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        byte_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and held data stays stable.

    logic [DATA_W-1:0] res_data;
    logic              res_mis;
    logic [31:0]       load_w;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic              m_mis_q, m_mis_d, s_mis_q, s_mis_d;
    logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic              accept, drain;

    assign load_w   = word[31:0];
    assign byte_sel = load_w[{byte_off, 3'b000} +: 8];
    assign half_sel = load_w[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        res_data = '0;
        res_mis  = 1'b0;
        case (op)
            3'd0: res_data = DATA_W'(imm);
            3'd1: res_data = DATA_W'($signed(imm));
            3'd2: res_data[DATA_W-1 -: IMM_W] = imm;
            3'd3: res_data = DATA_W'($signed(byte_sel));
            3'd4: res_data = DATA_W'(byte_sel);
            3'd5, 3'd6: begin
                if (byte_off[0]) begin
                    res_mis = 1'b1;
                end else if (op == 3'd5) begin
                    res_data = DATA_W'($signed(half_sel));
                end else begin
                    res_data = DATA_W'(half_sel);
                end
            end
            default: begin
                if (byte_off != 2'd0) begin
                    res_mis = 1'b1;
                end else begin
                    res_data = word;
                end
            end
        endcase
    end

    assign accept = in_valid && !s_valid_q;
    assign drain  = m_valid_q && out_ready;

    // S only ever fills while M is held, and refills M in order on the next drain.
    always_comb begin
        m_data_d  = m_data_q;
        m_mis_d   = m_mis_q;
        m_valid_d = m_valid_q;
        s_data_d  = s_data_q;
        s_mis_d   = s_mis_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            if (accept) begin
                m_data_d  = res_data;
                m_mis_d   = res_mis;
                m_valid_d = 1'b1;
            end
        end else if (!s_valid_q) begin
            if (accept && drain) begin
                m_data_d = res_data;
                m_mis_d  = res_mis;
            end else if (accept) begin
                s_data_d  = res_data;
                s_mis_d   = res_mis;
                s_valid_d = 1'b1;
            end else if (drain) begin
                m_valid_d = 1'b0;
            end
        end else if (drain) begin
            m_data_d  = s_data_q;
            m_mis_d   = s_mis_q;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_data_q  <= '0;
            m_mis_q   <= 1'b0;
            m_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_mis_q   <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_mis_q   <= m_mis_d;
            m_valid_q <= m_valid_d;
            s_data_q  <= s_data_d;
            s_mis_q   <= s_mis_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign in_ready     = !s_valid_q;
    assign out_valid    = m_valid_q;
    assign out_data     = m_data_q;
    assign out_misalign = m_mis_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: directed spec vectors, backpressure/flush/reset scenarios,
// a randomized run against a queue-based reference, and a 64-bit instance.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_misalign;
    logic [2:0]  op;
    logic [15:0] imm;
    logic [31:0] word;
    logic [1:0]  byte_off;
    logic [31:0] out_data;

    logic        in_valid64, in_ready64, out_valid64, out_mis64;
    logic [2:0]  op64;
    logic [7:0]  imm64;
    logic [63:0] word64, out_data64;
    logic [1:0]  off64;

    int n_checks = 0;
    int n_errors = 0;

    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    ext_pipe #(.IMM_W(16), .DATA_W(32)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .imm(imm), .word(word), .byte_off(byte_off),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_misalign(out_misalign)
    );

    ext_pipe #(.IMM_W(8), .DATA_W(64)) u_dut64 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .op(op64), .imm(imm64), .word(word64), .byte_off(off64),
        .out_valid(out_valid64), .out_ready(1'b1),
        .out_data(out_data64), .out_misalign(out_mis64)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference extension computed from the mode rules with plain arithmetic.
    function automatic logic [64:0] ref_ext(input int opc, input logic [63:0] iv,
                                            input logic [63:0] wv, input int off,
                                            input int imw, input int dw);
        logic [63:0] dm, im, r, b;
        logic        mis;
        dm  = (dw >= 64) ? '1 : (64'd1 << dw) - 64'd1;
        im  = (imw >= 64) ? '1 : (64'd1 << imw) - 64'd1;
        mis = 1'b0;
        r   = '0;
        case (opc)
            0: r = iv & im;
            1: r = (((iv >> (imw - 1)) & 64'd1) != 0) ? (((iv & im) | ~im) & dm) : (iv & im);
            2: r = ((iv & im) << (dw - imw)) & dm;
            3, 4: begin
                b = (wv >> (8 * off)) & 64'hFF;
                r = (opc == 3 && b >= 64'd128) ? ((b | ~64'hFF) & dm) : b;
            end
            5, 6: begin
                if (off % 2 == 1) mis = 1'b1;
                else begin
                    b = (wv >> (16 * (off / 2))) & 64'hFFFF;
                    r = (opc == 5 && b >= 64'd32768) ? ((b | ~64'hFFFF) & dm) : b;
                end
            end
            default: begin
                if (off != 0) mis = 1'b1;
                else r = wv & dm;
            end
        endcase
        return {mis, r};
    endfunction

    // One clock: update the reference queue at the edge, compare on the falling edge.
    task automatic step();
        bit          acc, drn, was_reset;
        logic [64:0] e;
        acc       = in_valid && (exp_q.size() < 2);
        drn       = (exp_q.size() > 0) && out_ready;
        was_reset = reset;
        e         = ref_ext(int'(op), 64'(imm), 64'(word), int'(byte_off), 16, 32);
        @(posedge clk);
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        @(negedge clk);
        check_val("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check_val("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check_val("out_data", 64'(out_data), 64'(exp_q[0][31:0]));
            check_val("out_misalign", 64'(out_misalign), 64'(exp_q[0][64]));
        end
        if (was_reset) begin
            check_val("reset_data", 64'(out_data), 64'd0);
            check_val("reset_mis", 64'(out_misalign), 64'd0);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] i,
                         input logic [31:0] w, input logic [1:0] off, input logic rdy);
        in_valid  = v;
        op        = o;
        imm       = i;
        word      = w;
        byte_off  = off;
        out_ready = rdy;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [15:0] i;
        logic [31:0] w;
        logic [1:0]  off;
        logic [31:0] d;
        logic        m;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{3'd0, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0};
        vecs[1]  = '{3'd1, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0};
        vecs[2]  = '{3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0};
        vecs[3]  = '{3'd3, 16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0};
        vecs[4]  = '{3'd3, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0};
        vecs[5]  = '{3'd4, 16'h0, 32'h80FF7F01, 2'd2, 32'h000000FF, 1'b0};
        vecs[6]  = '{3'd5, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0};
        vecs[7]  = '{3'd6, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0};
        vecs[8]  = '{3'd7, 16'h0, 32'h80FF7F01, 2'd0, 32'h80FF7F01, 1'b0};
        vecs[9]  = '{3'd5, 16'h0, 32'h80FF7F01, 2'd1, 32'h00000000, 1'b1};
        vecs[10] = '{3'd7, 16'h0, 32'h80FF7F01, 2'd2, 32'h00000000, 1'b1};
        vecs[11] = '{3'd4, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0};
        vecs[12] = '{3'd6, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000000, 1'b1};
        vecs[13] = '{3'd1, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0};
        vecs[14] = '{3'd0, 16'h1234, 32'hFFFFFFFF, 2'd3, 32'h00001234, 1'b0};

        reset = 1'b1;
        flush = 1'b0;
        in_valid64 = 1'b0; op64 = '0; imm64 = '0; word64 = '0; off64 = '0;
        drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0, 1'b1);
        step();
        step();
        reset = 1'b0;
        step();

        // Directed mode table, streamed back-to-back with out_ready high.
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].o, vecs[k].i, vecs[k].w, vecs[k].off, 1'b1);
            step();
            check_val($sformatf("vec%0d_data", k), 64'(out_data), 64'(vecs[k].d));
            check_val($sformatf("vec%0d_mis", k), 64'(out_misalign), 64'(vecs[k].m));
            check_val($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
        end
        drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0, 1'b1);
        step();

        // Backpressure: A, B, C, D on consecutive cycles, out_ready drops after A drains.
        drive(1'b1, 3'd0, 16'hA, 32'h0, 2'd0, 1'b1); step();
        drive(1'b1, 3'd0, 16'hB, 32'h0, 2'd0, 1'b1); step();
        drive(1'b1, 3'd0, 16'hC, 32'h0, 2'd0, 1'b0); step();
        check_val("bp_in_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, 3'd0, 16'hD, 32'h0, 2'd0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step();
            check_val("bp_stall_data", 64'(out_data), 64'hB);
            check_val("bp_stall_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check_val("bp_order_c", 64'(out_data), 64'hC);
        step();
        check_val("bp_order_d", 64'(out_data), 64'hD);
        in_valid = 1'b0;
        step();
        check_val("bp_empty", 64'(out_valid), 64'd0);

        // Flush with M and S full, alongside a new request.
        drive(1'b1, 3'd0, 16'h11, 32'h0, 2'd0, 1'b0); step();
        drive(1'b1, 3'd0, 16'h22, 32'h0, 2'd0, 1'b0); step();
        drive(1'b1, 3'd0, 16'h33, 32'h0, 2'd0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 3'd0, 16'h44, 32'h0, 2'd0, 1'b1); step();
        check_val("flush_next", 64'(out_data), 64'h44);
        in_valid = 1'b0;
        step();

        // Reset mid-stream.
        drive(1'b1, 3'd0, 16'h55, 32'h0, 2'd0, 1'b0); step();
        drive(1'b1, 3'd0, 16'h66, 32'h0, 2'd0, 1'b0); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 3'd1, 16'hFF00, 32'h0, 2'd0, 1'b1); step();
        check_val("rst_next", 64'(out_data), 64'hFFFFFF00);
        in_valid = 1'b0;
        step();

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  16'($urandom), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 6));
            flush = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        flush = 1'b0;
        reset = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0, 1'b1);
        step();
        step();

        // 64-bit / 8-bit immediate instance.
        begin
            logic [2:0]  ops64[3] = '{3'd1, 3'd2, 3'd3};
            logic [63:0] req64[3] = '{64'hFFFFFFFFFFFFFFF0, 64'hF000000000000000,
                                      64'hFFFFFFFFFFFFFF80};
            logic [64:0] r;
            for (int k = 0; k < 3; k++) begin
                in_valid64 = 1'b1;
                op64       = ops64[k];
                imm64      = 8'hF0;
                word64     = 64'h0000_0000_0000_0080;
                off64      = 2'd0;
                step();
                in_valid64 = 1'b0;
                r = ref_ext(int'(ops64[k]), 64'(imm64), word64, 0, 8, 64);
                check_val($sformatf("w64_op%0d_valid", ops64[k]), 64'(out_valid64), 64'd1);
                check_val($sformatf("w64_op%0d_const", ops64[k]), out_data64, req64[k]);
                check_val($sformatf("w64_op%0d_model", ops64[k]), out_data64, r[63:0]);
                check_val($sformatf("w64_op%0d_mis", ops64[k]), 64'(out_mis64), 64'(r[64]));
            end
            step();
            check_val("w64_drained", 64'(out_valid64), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
